// File: rtl/sseg_pkg.sv
// Shared definitions for the self-scanning seven-segment controller:
// segment patterns (active-low {g,f,e,d,c,b,a}) and the load FSM states.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  // Glyph for one hex/BCD nibble, lower-case b and d so they differ from 8 and 0
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pattern;
    case (nib)
      4'h0: pattern = 7'b1000000;
      4'h1: pattern = 7'b1111001;
      4'h2: pattern = 7'b0100100;
      4'h3: pattern = 7'b0110000;
      4'h4: pattern = 7'b0011001;
      4'h5: pattern = 7'b0010010;
      4'h6: pattern = 7'b0000010;
      4'h7: pattern = 7'b1111000;
      4'h8: pattern = 7'b0000000;
      4'h9: pattern = 7'b0010000;
      4'hA: pattern = 7'b0001000;
      4'hB: pattern = 7'b0000011;
      4'hC: pattern = 7'b1000110;
      4'hD: pattern = 7'b0100001;
      4'hE: pattern = 7'b0000110;
      4'hF: pattern = 7'b0001110;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter. The first shift happens in the start
// cycle itself (the BCD register is all zero then, so no add-3 is needed),
// which lets the result be flagged valid after DATA_W shift steps in total.
// Any 1 pushed out of the top BCD nibble means the value needs more digits.
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q;
  logic [CNT_W-1:0]  steps_left;
  logic [BCD_W-1:0]  adj;

  // Add 3 to every nibble that is 5 or more before the next left shift
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift engine: load on start, then one adjust-and-shift per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd        <= '0;
      ovf        <= 1'b0;
      steps_left <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        bin_q      <= data << 1;
        bcd        <= BCD_W'(data[DATA_W-1]);
        ovf        <= 1'b0;
        steps_left <= CNT_W'(DATA_W - 1);
        valid      <= (DATA_W == 1);
      end else if (steps_left != '0) begin
        bin_q      <= bin_q << 1;
        bcd        <= {adj[BCD_W-2:0], bin_q[DATA_W-1]};
        ovf        <= ovf | adj[BCD_W-1];
        steps_left <= steps_left - CNT_W'(1);
        valid      <= (steps_left == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Seven-segment display controller: takes a value through a load handshake,
// converts it (decimal via double-dabble, or hex nibbles), applies sign,
// leading-zero blanking and overflow, and scans DIGITS common-anode digits.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_CNT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              hex_dec,
  input  logic              signed_mode,
  input  logic              lz_blank,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

  state_t            state;
  logic [BCD_W-1:0]  val_q;
  logic              neg_q;
  logic              lz_q;
  logic              pre_ovf_q;
  logic [6:0]        disp [DIGITS];

  logic [31:0]       data_ext;
  logic              is_neg_in;
  logic [DATA_W-1:0] magnitude;
  logic              hex_ovf_in;
  logic [BCD_W-1:0]  hex_val_in;
  logic              conv_start;
  logic [BCD_W-1:0]  conv_bcd;
  logic              conv_ovf;
  logic              conv_valid;

  int                msd;
  logic              sign_ovf;
  logic              next_ovf;
  logic [6:0]        next_disp [DIGITS];

  logic [CNT_W-1:0]  refresh_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] an_sel;

  // Prepare the incoming value: magnitude for decimal, nibbles and range check for hex
  always_comb begin
    data_ext   = 32'(data);
    is_neg_in  = signed_mode && data[DATA_W-1];
    magnitude  = is_neg_in ? (~data + DATA_W'(1)) : data;
    hex_ovf_in = (data_ext >> BCD_W) != 32'd0;
    hex_val_in = BCD_W'(data_ext);
    conv_start = (state == ST_IDLE) && load && !hex_dec;
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .data  (magnitude),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf),
    .valid (conv_valid)
  );

  // Build the full set of digit glyphs that COMMIT will latch in one go
  always_comb begin
    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (val_q[4*i +: 4] != 4'd0) msd = i;
    end
    // With or without blanking the minus needs a digit above the top nonzero one
    sign_ovf = neg_q && (msd == DIGITS - 1);
    next_ovf = pre_ovf_q || sign_ovf;
    for (int i = 0; i < DIGITS; i++) begin
      next_disp[i] = hex_to_seg(val_q[4*i +: 4]);
      if (next_ovf) begin
        next_disp[i] = SEG_MINUS;
      end else if (neg_q && (i == (lz_q ? msd + 1 : DIGITS - 1))) begin
        next_disp[i] = SEG_MINUS;
      end else if (lz_q && (i > msd)) begin
        next_disp[i] = SEG_BLANK;
      end
    end
  end

  // Load FSM: capture on accepted load, convert, then swap the display register atomically
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      val_q     <= '0;
      neg_q     <= 1'b0;
      lz_q      <= 1'b1;
      pre_ovf_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        disp[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            lz_q <= lz_blank;
            busy <= 1'b1;
            if (hex_dec) begin
              val_q     <= hex_val_in;
              pre_ovf_q <= hex_ovf_in;
              neg_q     <= 1'b0;
              state     <= ST_COMMIT;
            end else begin
              neg_q     <= is_neg_in;
              pre_ovf_q <= 1'b0;
              state     <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          if (conv_valid) begin
            val_q     <= conv_bcd;
            pre_ovf_q <= conv_ovf;
            state     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < DIGITS; i++) begin
            disp[i] <= next_disp[i];
          end
          ovf   <= next_ovf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-hot-low anode pattern for the digit currently being scanned
  always_comb begin
    an_sel        = '1;
    an_sel[idx_q] = 1'b0;
  end

  // Refresh scan: anode, segments and decimal point all register on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
      seg       <= SEG_BLANK;
      an        <= '1;
      dp        <= 1'b1;
    end else begin
      seg <= disp[idx_q];
      dp  <= ~dp_in[idx_q];
      an  <= an_sel;
      if (refresh_q == CNT_W'(REFRESH_CNT - 1)) begin
        refresh_q <= '0;
        idx_q     <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        refresh_q <= refresh_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: a behavioural model computes the
// expected display from plain arithmetic and a cycle schedule, a compare
// process checks every output each cycle, and directed literal checks pin
// the model to hand-worked examples.
module tb_sseg_scan_ctrl;

  localparam int DIGITS      = 4;
  localparam int DATA_W      = 16;
  localparam int REFRESH_CNT = 4;

  localparam logic [6:0] T_BLANK = 7'b1111111;
  localparam logic [6:0] T_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data;
  logic              hex_dec;
  logic              signed_mode;
  logic              lz_blank;
  logic [DIGITS-1:0] dp_in;
  logic              load;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;

  int n_checks = 0;
  int n_pass   = 0;

  sseg_scan_ctrl #(
    .DIGITS      (DIGITS),
    .DATA_W      (DATA_W),
    .REFRESH_CNT (REFRESH_CNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .hex_dec     (hex_dec),
    .signed_mode (signed_mode),
    .lz_blank    (lz_blank),
    .dp_in       (dp_in),
    .load        (load),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it if it does not match
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic failTimeout(input string name);
    n_checks++;
    $display("[TB] FAIL %s: timed out waiting, expected event never came", name);
  endtask

  // Expected glyphs and overflow for a value, straight from the display rules
  function automatic void expect_display(input logic [15:0] v, input bit hx, input bit sg,
                                         input bit lz, output logic [3:0][6:0] d, output bit o);
    int mag, nd, base;
    bit neg;
    base = hx ? 16 : 10;
    neg  = !hx && sg && v[15];
    mag  = neg ? 65536 - int'(v) : int'(v);
    o    = !hx && (mag >= 10000);
    nd   = 1;
    for (int k = 1; k < DIGITS; k++) if (mag >= base ** k) nd = k + 1;
    if (neg && nd >= DIGITS) o = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (o) d[i] = T_MINUS;
      else if (neg && i == (lz ? nd : DIGITS - 1)) d[i] = T_MINUS;
      else if (lz && i >= nd) d[i] = T_BLANK;
      else d[i] = SEG_LUT[(mag / (base ** i)) % base];
    end
  endfunction

  // Reference model state, advanced once per rising edge
  int               cyc = 0;
  bit               m_valid = 0;
  bit               m_busy, m_done, m_ovf, m_dp;
  logic [6:0]       m_seg;
  logic [3:0]       m_an;
  logic [6:0]       m_disp [DIGITS];
  int               m_idx, m_cnt;
  bit               pend;
  int               commit_at;
  logic [3:0][6:0]  pend_disp;
  bit               pend_ovf;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_done = 0; m_ovf = 0; m_dp = 1;
      m_seg = T_BLANK; m_an = 4'hF;
      m_disp[0] = SEG_LUT[0];
      for (int k = 1; k < DIGITS; k++) m_disp[k] = T_BLANK;
      m_idx = 0; m_cnt = 0; pend = 0;
    end else begin
      m_seg = m_disp[m_idx];
      m_an  = 4'hF;
      m_an[m_idx] = 1'b0;
      m_dp  = !dp_in[m_idx];
      if (m_cnt == REFRESH_CNT - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_cnt++;
      end
      m_done = 0;
      if (pend && cyc == commit_at) begin
        for (int k = 0; k < DIGITS; k++) m_disp[k] = pend_disp[k];
        m_ovf = pend_ovf; m_done = 1; m_busy = 0; pend = 0;
      end else if (!m_busy && load) begin
        expect_display(data, hex_dec, signed_mode, lz_blank, pend_disp, pend_ovf);
        pend = 1; m_busy = 1;
        commit_at = cyc + (hex_dec ? 1 : DATA_W + 1);
      end
    end
    m_valid = 1;
  end

  // Every cycle, every output against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("cyc_busy", busy, m_busy);
      checkOutput("cyc_done", done, m_done);
      checkOutput("cyc_ovf",  ovf,  m_ovf);
      checkOutput("cyc_seg",  seg,  m_seg);
      checkOutput("cyc_an",   an,   m_an);
      checkOutput("cyc_dp",   dp,   m_dp);
    end
  end

  // Wait for idle, then present one load for a single cycle
  task automatic applyStimulus(input logic [15:0] v, input bit hx, input bit sg, input bit lz);
    bit idle = 0;
    for (int k = 0; k < 60; k++) begin
      if (!busy) begin idle = 1; break; end
      @(negedge clk);
    end
    if (!idle) failTimeout("idle_before_load");
    data = v; hex_dec = hx; signed_mode = sg; lz_blank = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Count busy cycles and the cycle index of done, starting one cycle after the load
  task automatic measureLoad(input string name, input int exp_busy, input int exp_lat);
    int nb = 0, lat = 1;
    bit got = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin got = 1; break; end
      if (busy) nb++;
      lat++;
      @(negedge clk);
    end
    if (!got) failTimeout({name, "_done"});
    else begin
      checkOutput({name, "_busy_cycles"}, nb, exp_busy);
      checkOutput({name, "_done_latency"}, lat, exp_lat);
    end
  endtask

  // Advance until the given anode is lit, then check its glyph and point
  task automatic seekDigit(input logic [3:0] pat, input string name,
                           input logic [6:0] exp_seg, input logic exp_dp);
    bit found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (an == pat) begin found = 1; break; end
    end
    if (!found) failTimeout({name, "_an"});
    else begin
      checkOutput({name, "_seg"}, seg, exp_seg);
      checkOutput({name, "_dp"}, dp, exp_dp);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0][6:0] pd;
    bit po;
    rst = 1; load = 0; data = '0; hex_dec = 0; signed_mode = 0; lz_blank = 1; dp_in = '0;

    expect_display(16'hFFFB, 0, 1, 1, pd, po);
    checkOutput("model_neg5_d0", pd[0], 7'b0010010);
    checkOutput("model_neg5_d1", pd[1], 7'b0111111);
    checkOutput("model_neg5_d2", pd[2], 7'b1111111);
    expect_display(16'd12345, 0, 0, 1, pd, po);
    checkOutput("model_12345_ovf", po, 1);
    expect_display(16'hBEEF, 1, 0, 1, pd, po);
    checkOutput("model_beef_d3", pd[3], 7'b0000011);

    repeat (3) @(negedge clk);
    checkOutput("rst_seg", seg, 7'b1111111);
    checkOutput("rst_an", an, 4'b1111);
    checkOutput("rst_dp", dp, 1);
    checkOutput("rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    checkOutput("first_an", an, 4'b1110);
    checkOutput("first_seg", seg, 7'b1000000);
    seekDigit(4'b1101, "rst_d1", 7'b1111111, 1);
    seekDigit(4'b1011, "rst_d2", 7'b1111111, 1);
    seekDigit(4'b0111, "rst_d3", 7'b1111111, 1);

    $display("[TB] decimal 1234");
    applyStimulus(16'd1234, 0, 0, 1);
    measureLoad("d1234", 17, 18);
    seekDigit(4'b1110, "d1234_d0", 7'b0011001, 1);
    seekDigit(4'b1101, "d1234_d1", 7'b0110000, 1);
    seekDigit(4'b1011, "d1234_d2", 7'b0100100, 1);
    seekDigit(4'b0111, "d1234_d3", 7'b1111001, 1);

    $display("[TB] signed -5 with blanking");
    applyStimulus(16'hFFFB, 0, 1, 1);
    measureLoad("neg5", 17, 18);
    checkOutput("neg5_ovf", ovf, 0);
    seekDigit(4'b1110, "neg5_d0", 7'b0010010, 1);
    seekDigit(4'b1101, "neg5_d1", 7'b0111111, 1);
    seekDigit(4'b1011, "neg5_d2", 7'b1111111, 1);
    seekDigit(4'b0111, "neg5_d3", 7'b1111111, 1);

    $display("[TB] overflow cases");
    applyStimulus(16'd12345, 0, 0, 1);
    measureLoad("d12345", 17, 18);
    checkOutput("d12345_ovf", ovf, 1);
    seekDigit(4'b1110, "d12345_d0", 7'b0111111, 1);
    seekDigit(4'b0111, "d12345_d3", 7'b0111111, 1);
    applyStimulus(16'hFB2E, 0, 1, 1);
    measureLoad("neg1234", 17, 18);
    checkOutput("neg1234_ovf", ovf, 1);

    $display("[TB] signed -7 without blanking");
    applyStimulus(16'hFFF9, 0, 1, 0);
    measureLoad("neg7", 17, 18);
    checkOutput("neg7_ovf", ovf, 0);
    seekDigit(4'b1110, "neg7_d0", 7'b1111000, 1);
    seekDigit(4'b1011, "neg7_d2", 7'b1000000, 1);
    seekDigit(4'b0111, "neg7_d3", 7'b0111111, 1);

    $display("[TB] hex BEEF with decimal point on digit 2");
    dp_in = 4'b0100;
    applyStimulus(16'hBEEF, 1, 0, 1);
    measureLoad("beef", 1, 2);
    seekDigit(4'b1110, "beef_d0", 7'b0001110, 1);
    seekDigit(4'b1101, "beef_d1", 7'b0000110, 1);
    seekDigit(4'b1011, "beef_d2", 7'b0000110, 0);
    seekDigit(4'b0111, "beef_d3", 7'b0000011, 1);
    dp_in = 4'b0000;

    $display("[TB] load during busy is dropped");
    applyStimulus(16'd1234, 0, 0, 0);
    data = 16'd9999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    measureLoad("drop", 16, 17);
    seekDigit(4'b1110, "drop_d0", 7'b0011001, 1);
    seekDigit(4'b0111, "drop_d3", 7'b1111001, 1);
    checkOutput("drop_not_busy", busy, 0);

    $display("[TB] randomized loads");
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c % 50 == 0) dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: data = 16'($urandom);
          1: data = 16'($urandom_range(0, 20));
          2: data = 16'(65536 - $urandom_range(1, 1200));
          default: data = 16'($urandom_range(9990, 10010));
        endcase
        hex_dec     = 1'($urandom_range(0, 1));
        signed_mode = 1'($urandom_range(0, 1));
        lz_blank    = 1'($urandom_range(0, 1));
        load        = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;

    $display("[TB] reset in the middle of a conversion");
    applyStimulus(16'd4321, 0, 0, 1);
    repeat (4) @(negedge clk);
    checkOutput("midrst_busy_before", busy, 1);
    rst = 1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_seg", seg, 7'b1111111);
    rst = 0;
    @(negedge clk);
    checkOutput("midrst_an", an, 4'b1110);
    checkOutput("midrst_zero", seg, 7'b1000000);
    seekDigit(4'b1101, "midrst_d1", 7'b1111111, 1);
    repeat (30) @(negedge clk);
    checkOutput("midrst_ovf", ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
